// File: rtl/parity_serial_rx.sv
// parity_serial_rx: oversampling serial frame receiver with XOR/XNOR parity and framing checks.
// Frame is start(0), DATA_W data bits LSB first, parity, stop(1); each bit sampled mid-bit.
module parity_serial_rx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter bit ODD_PARITY   = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W) + 1;
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_W - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_e;
  state_e            state_q;
  logic              rx_meta_q, rx_s_q, rx_prev_q, par_acc_q, perr_q;
  logic [CW-1:0]     clk_cnt_q;
  logic [BW-1:0]     bit_cnt_q;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tick;
  // new bit enters at the MSB so the first (LSB) data bit ends up in bit 0
  assign shift_d = DATA_W'({rx_s_q, shift_q} >> 1);
  assign tick    = clk_cnt_q == FULL;
  assign busy    = state_q != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      par_acc_q  <= 1'b0;
      perr_q     <= 1'b0;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_s_q     <= rx_meta_q;
      rx_prev_q  <= rx_s_q;
      data_valid <= 1'b0;
      case (state_q)
        IDLE: if (rx_prev_q && !rx_s_q) begin
          state_q   <= START;
          clk_cnt_q <= '0;
        end
        START: if (clk_cnt_q == HALF) begin
          clk_cnt_q <= '0;
          bit_cnt_q <= '0;
          par_acc_q <= 1'b0;
          state_q   <= rx_s_q ? IDLE : DATA;
        end else clk_cnt_q <= clk_cnt_q + CW'(1);
        DATA: if (tick) begin
          clk_cnt_q <= '0;
          shift_q   <= shift_d;
          par_acc_q <= par_acc_q ^ rx_s_q;
          bit_cnt_q <= bit_cnt_q + BW'(1);
          if (bit_cnt_q == LAST) state_q <= PARITY;
        end else clk_cnt_q <= clk_cnt_q + CW'(1);
        PARITY: if (tick) begin
          clk_cnt_q <= '0;
          perr_q    <= par_acc_q ^ rx_s_q ^ ODD_PARITY;
          state_q   <= STOP;
        end else clk_cnt_q <= clk_cnt_q + CW'(1);
        STOP: if (tick) begin
          clk_cnt_q  <= '0;
          data_out   <= shift_q;
          parity_err <= perr_q;
          frame_err  <= ~rx_s_q;
          data_valid <= 1'b1;
          state_q    <= rx_s_q ? IDLE : WAIT_HIGH;
        end else clk_cnt_q <= clk_cnt_q + CW'(1);
        WAIT_HIGH: if (rx_s_q) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
